axi_rd_arb2: RTL and testbench
==============================

AXI_RD_ARB2 -- requirements
Module: axi_rd_arb2

Interface
REQ-001 The block SHALL have input clock: 1 bit, the only clock; reset is synchronous, active-high, and named reset.
REQ-002 The block SHALL have input reset: 1 bit, returns all state to reset values on the clock edge.
REQ-003 The block SHALL have input m{0,1}_ar_valid: 1 bit per port, read request (m0 = fetch, m1 = load/store).
REQ-004 The block SHALL have output m{0,1}_ar_ready: 1 bit per port, request accepted.
REQ-005 The block SHALL have input m{0,1}_araddr: 64 bits per port, burst start address.
REQ-006 The block SHALL have input m{0,1}_arlen: 8 bits per port, beats minus 1; bits 7:4 are zero.
REQ-007 The block SHALL have output m{0,1}_r_valid: 1 bit per port, beat for this port; the master has no ready and takes every beat.
REQ-008 The block SHALL have output m{0,1}_rdata: 64 bits per port, copy of s_rdata.
REQ-009 The block SHALL have output m{0,1}_rlast: 1 bit per port, last beat for this port.
REQ-010 The block SHALL have output s_ar_valid: 1 bit, request to the RAM slave.
REQ-011 The block SHALL have input s_ar_ready: 1 bit, slave accept.
REQ-012 The block SHALL have output s_araddr: 64 bits, registered address to the slave.
REQ-013 The block SHALL have output s_arlen: 8 bits, registered length to the slave.
REQ-014 The block SHALL have input s_r_valid: 1 bit, slave beat; there is no r_ready.
REQ-015 The block SHALL have input s_rdata: 64 bits, slave data.
REQ-016 The block SHALL have input s_rlast: 1 bit, slave last beat.
REQ-017 The block SHALL have output grant_id: 1 bit, port owning the slave (meaningful in ADDR/DATA).
REQ-018 The block SHALL have output arb_err: 1 bit, sticky protocol-error flag.

Function
REQ-019 The FSM SHALL have states IDLE, ADDR and DATA; reset state is IDLE.
REQ-020 In IDLE, the winner SHALL be taken among the asserted m*_ar_valid; with both asserted the winner is port ptr; ptr is 1 bit with reset value 0.
REQ-021 In IDLE, m{winner}_ar_ready SHALL be 1 combinationally, the loser and non-requesters get 0, and with no request both readies are 0.
REQ-022 On a master handshake, the block SHALL latch araddr, arlen and grant, and go to ADDR on the next cycle.
REQ-023 In ADDR, s_ar_valid SHALL be 1 and s_araddr/s_arlen SHALL come from the latches; on s_ar_valid & s_ar_ready, the block loads beat counter cnt (8 bits) with the latched arlen and goes to DATA.
REQ-024 Latency SHALL be: master fire at cycle t, then s_ar_valid at t+1, with both m*_ar_ready 0 from t+1 until return to IDLE.
REQ-025 In DATA, m{grant}_r_valid SHALL equal s_r_valid and m{grant}_rlast SHALL equal s_rlast & s_r_valid; the other port's r_valid and rlast are 0; rdata is broadcast to both ports.
REQ-026 Each s_r_valid beat in DATA SHALL decrement cnt, saturating at 0.
REQ-027 On s_r_valid & s_rlast in DATA, the block SHALL go to IDLE and set ptr to ~grant, so a new grant is possible the following cycle.
REQ-028 arb_err SHALL be set if any of these occurs: s_rlast with cnt != 0; a beat with cnt == 0 and no s_rlast; s_r_valid outside DATA. In the second case the block stays in DATA until s_rlast; stray beats outside DATA are not forwarded.
REQ-029 arb_err SHALL clear only on reset.
REQ-030 s_ar_valid SHALL be 0 in IDLE and DATA.

Reset
REQ-031 On reset, the outputs and state SHALL take these values: m*_ar_ready 0, m*_r_valid 0, m*_rlast 0, s_ar_valid 0, s_araddr 0, s_arlen 0, grant_id 0, arb_err 0, cnt 0, ptr 0, state IDLE.
REQ-032 A reset asserted mid-burst SHALL abandon the burst with no beat forwarded after it; the slave shares the same reset.

Configuration
REQ-033 With ARB_FIXED_PRIO_EN defined, m1 SHALL always win ties and ptr is not updated.
REQ-034 Without ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-020 and REQ-027.

Verification
REQ-035 Bench SHALL cover: m0 alone, araddr 0x80000000, arlen 3 -> m0_ar_ready at t, s_ar_valid at t+1, 4 beats on m0 only, m0_rlast on the 4th beat, arb_err 0.
REQ-036 Bench SHALL cover: m0 and m1 both asserted from reset -> m0 is granted first, m1 next, m0 after that (round-robin); with ARB_FIXED_PRIO_EN, m1 is granted every time.
REQ-037 Bench SHALL cover: m1 request arriving during an m0 burst -> m1_ar_ready stays 0 until the cycle after m0's rlast.
REQ-038 Bench SHALL cover: arlen 1 with slave rlast forced on beat 1 -> arb_err 1 and the FSM returns to IDLE.
REQ-039 Bench SHALL cover: reset at the 2nd beat of a 4-beat burst -> all outputs 0 the next cycle, and a new m1 request is then served normally.

Source files
------------

// File: rtl/axi_rd_arb2.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arb2
// Description : Two-master AXI read-channel arbiter (m0 fetch, m1 load/store)
//               sharing one RAM slave. Round-robin by default; define
//               ARB_FIXED_PRIO_EN for fixed priority with m1 winning ties.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arb2 (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_ar_valid,
    output logic        m0_ar_ready,
    input  logic [63:0] m0_araddr,
    input  logic [7:0]  m0_arlen,
    output logic        m0_r_valid,
    output logic [63:0] m0_rdata,
    output logic        m0_rlast,
    input  logic        m1_ar_valid,
    output logic        m1_ar_ready,
    input  logic [63:0] m1_araddr,
    input  logic [7:0]  m1_arlen,
    output logic        m1_r_valid,
    output logic [63:0] m1_rdata,
    output logic        m1_rlast,
    output logic        s_ar_valid,
    input  logic        s_ar_ready,
    output logic [63:0] s_araddr,
    output logic [7:0]  s_arlen,
    input  logic        s_r_valid,
    input  logic [63:0] s_rdata,
    input  logic        s_rlast,
    output logic        grant_id,
    output logic        arb_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_grant;
    logic [63:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic        r_err;
`ifndef ARB_FIXED_PRIO_EN
    logic        r_ptr;
`endif

    logic w_win;
    logic w_fire;
    logic w_s_fire;
    logic w_in_data;
    logic w_beat;
    logic w_err_evt;

    always_comb begin
        // m1 wins whenever it requests under fixed priority; otherwise ties go to ptr
`ifdef ARB_FIXED_PRIO_EN
        w_win = m1_ar_valid;
`else
        w_win = (m0_ar_valid & m1_ar_valid) ? r_ptr : m1_ar_valid;
`endif
        w_fire      = (r_state == S_IDLE) & (m0_ar_valid | m1_ar_valid);
        m0_ar_ready = w_fire & ~w_win;
        m1_ar_ready = w_fire & w_win;
        s_ar_valid  = (r_state == S_ADDR);
        w_s_fire    = s_ar_valid & s_ar_ready;
        w_in_data   = (r_state == S_DATA);
        w_beat      = w_in_data & s_r_valid;
        m0_r_valid  = w_beat & ~r_grant;
        m1_r_valid  = w_beat & r_grant;
        m0_rlast    = w_beat & s_rlast & ~r_grant;
        m1_rlast    = w_beat & s_rlast & r_grant;
        m0_rdata    = s_rdata;
        m1_rdata    = s_rdata;
        w_err_evt   = (w_beat & s_rlast & (r_cnt != 8'd0))
                    | (w_beat & ~s_rlast & (r_cnt == 8'd0))
                    | (s_r_valid & ~w_in_data);

        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_fire) w_state_nxt = S_ADDR;
            S_ADDR:  if (w_s_fire) w_state_nxt = S_DATA;
            S_DATA:  if (w_beat & s_rlast) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_addr  <= 64'd0;
            r_len   <= 8'd0;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            r_ptr   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_fire) begin
                r_grant <= w_win;
                r_addr  <= w_win ? m1_araddr : m0_araddr;
                r_len   <= w_win ? m1_arlen : m0_arlen;
            end
            if (w_s_fire) begin
                r_cnt <= r_len;
            end
            if (w_beat && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
`ifndef ARB_FIXED_PRIO_EN
            if (w_beat && s_rlast) begin
                r_ptr <= ~r_grant;
            end
`endif
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
        end
    end

    assign s_araddr = r_addr;
    assign s_arlen  = r_len;
    assign grant_id = r_grant;
    assign arb_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_arb2
// Description : Directed self-checking bench for axi_rd_arb2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arb2;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_ar_valid, m1_ar_valid;
    logic        m0_ar_ready, m1_ar_ready;
    logic [63:0] m0_araddr, m1_araddr;
    logic [7:0]  m0_arlen, m1_arlen;
    logic        m0_r_valid, m1_r_valid;
    logic [63:0] m0_rdata, m1_rdata;
    logic        m0_rlast, m1_rlast;
    logic        s_ar_valid, s_ar_ready;
    logic [63:0] s_araddr;
    logic [7:0]  s_arlen;
    logic        s_r_valid;
    logic [63:0] s_rdata;
    logic        s_rlast;
    logic        grant_id, arb_err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    axi_rd_arb2 dut (
        .clock(clock), .reset(reset),
        .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
        .m0_r_valid(m0_r_valid), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
        .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
        .m1_r_valid(m1_r_valid), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_r_valid(s_r_valid), .s_rdata(s_rdata), .s_rlast(s_rlast),
        .grant_id(grant_id), .arb_err(arb_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_ar_valid = 0; m1_ar_valid = 0;
        s_ar_ready = 0; s_r_valid = 0; s_rlast = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // One round of a both-requesting arbitration with a single-beat burst.
    task automatic rr_round(input string tag, input logic exp_win);
        settle();
        chk({tag, "_m0_ready"}, m0_ar_ready, !exp_win);
        chk({tag, "_m1_ready"}, m1_ar_ready, exp_win);
        tick();
        chk({tag, "_grant"}, grant_id, exp_win);
        chk({tag, "_s_ar_valid"}, s_ar_valid, 1);
        s_ar_ready = 1; tick(); s_ar_ready = 0;
        s_r_valid = 1; s_rlast = 1; s_rdata = 64'h55;
        settle();
        chk({tag, "_m0_rvalid"}, m0_r_valid, !exp_win);
        chk({tag, "_m1_rvalid"}, m1_r_valid, exp_win);
        tick();
        s_r_valid = 0; s_rlast = 0;
    endtask

    logic exp_first;

    initial begin
        m0_araddr = 0; m1_araddr = 0; m0_arlen = 0; m1_arlen = 0; s_rdata = 0;
        do_reset();
        settle();
        chk("rst_m0_ready", m0_ar_ready, 0);
        chk("rst_m1_ready", m1_ar_ready, 0);
        chk("rst_s_ar_valid", s_ar_valid, 0);
        chk("rst_s_araddr", s_araddr, 0);
        chk("rst_s_arlen", s_arlen, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_err", arb_err, 0);
        chk("rst_m0_rvalid", m0_r_valid, 0);
        chk("rst_m1_rvalid", m1_r_valid, 0);

        // m0 alone, 4-beat burst
        m0_ar_valid = 1; m0_araddr = 64'h8000_0000; m0_arlen = 8'd3;
        settle();
        chk("a_m0_ready_t", m0_ar_ready, 1);
        chk("a_m1_ready_t", m1_ar_ready, 0);
        tick();
        m0_ar_valid = 0;
        settle();
        chk("a_s_ar_valid_t1", s_ar_valid, 1);
        chk("a_s_araddr", s_araddr, 64'h8000_0000);
        chk("a_s_arlen", s_arlen, 3);
        chk("a_m0_ready_t1", m0_ar_ready, 0);
        s_ar_ready = 1; tick(); s_ar_ready = 0;
        settle();
        chk("a_s_ar_valid_data", s_ar_valid, 0);
        for (int i = 0; i < 4; i++) begin
            s_r_valid = 1; s_rlast = (i == 3); s_rdata = 64'hA000 + 64'(i);
            settle();
            chk("a_m0_rvalid", m0_r_valid, 1);
            chk("a_m1_rvalid", m1_r_valid, 0);
            chk("a_m0_rlast", m0_rlast, (i == 3));
            chk("a_m0_rdata", m0_rdata, 64'hA000 + 64'(i));
            tick();
        end
        s_r_valid = 0; s_rlast = 0;
        settle();
        chk("a_err", arb_err, 0);

        // both requesting from reset
        do_reset();
        m0_ar_valid = 1; m1_ar_valid = 1;
        m0_araddr = 64'h100; m1_araddr = 64'h200; m0_arlen = 0; m1_arlen = 0;
`ifdef ARB_FIXED_PRIO_EN
        exp_first = 1'b1;
        rr_round("b1", 1'b1);
        rr_round("b2", 1'b1);
        rr_round("b3", 1'b1);
`else
        exp_first = 1'b0;
        rr_round("b1", 1'b0);
        rr_round("b2", 1'b1);
        rr_round("b3", 1'b0);
`endif
        m0_ar_valid = 0; m1_ar_valid = 0;
        chk("b_err", arb_err, 0);

        // m1 arrives during an m0 burst
        do_reset();
        m0_ar_valid = 1; m0_araddr = 64'h300; m0_arlen = 1;
        tick();
        m0_ar_valid = 0; m1_ar_valid = 1; m1_araddr = 64'h400; m1_arlen = 0;
        settle();
        chk("c_m1_ready_addr", m1_ar_ready, 0);
        s_ar_ready = 1; tick(); s_ar_ready = 0;
        s_r_valid = 1; s_rlast = 0;
        settle();
        chk("c_m1_ready_beat1", m1_ar_ready, 0);
        tick();
        s_rlast = 1;
        settle();
        chk("c_m0_rlast", m0_rlast, 1);
        chk("c_m1_ready_last", m1_ar_ready, 0);
        tick();
        s_r_valid = 0; s_rlast = 0;
        settle();
        chk("c_m1_ready_after", m1_ar_ready, 1);
        tick();
        m1_ar_valid = 0;
        chk("c_grant", grant_id, 1);
        chk("c_s_araddr", s_araddr, 64'h400);
        s_ar_ready = 1; tick(); s_ar_ready = 0;
        s_r_valid = 1; s_rlast = 1;
        settle();
        chk("c_m1_rvalid", m1_r_valid, 1);
        chk("c_m0_rvalid", m0_r_valid, 0);
        chk("c_m1_rlast", m1_rlast, 1);
        tick();
        s_r_valid = 0; s_rlast = 0;
        chk("c_err", arb_err, 0);

        // arlen 1 with early rlast
        m0_ar_valid = 1; m0_arlen = 1;
        tick();
        m0_ar_valid = 0;
        s_ar_ready = 1; tick(); s_ar_ready = 0;
        s_r_valid = 1; s_rlast = 1;
        tick();
        s_r_valid = 0; s_rlast = 0;
        m1_ar_valid = 1;
        settle();
        chk("d_err", arb_err, 1);
        chk("d_idle_m1_ready", m1_ar_ready, 1);
        m1_ar_valid = 0;
        s_r_valid = 1;
        settle();
        chk("d_stray_m0", m0_r_valid, 0);
        chk("d_stray_m1", m1_r_valid, 0);
        tick();
        s_r_valid = 0;
        chk("d_err_sticky", arb_err, 1);

        // reset at the 2nd beat of a 4-beat burst
        do_reset();
        chk("e_err_cleared", arb_err, 0);
        m0_ar_valid = 1; m0_araddr = 64'h500; m0_arlen = 3;
        tick();
        m0_ar_valid = 0;
        s_ar_ready = 1; tick(); s_ar_ready = 0;
        s_r_valid = 1; s_rlast = 0;
        tick();
        reset = 1;
        tick();
        reset = 0; s_r_valid = 0;
        settle();
        chk("e_m0_rvalid", m0_r_valid, 0);
        chk("e_m0_ready", m0_ar_ready, 0);
        chk("e_s_ar_valid", s_ar_valid, 0);
        chk("e_s_araddr", s_araddr, 0);
        chk("e_s_arlen", s_arlen, 0);
        chk("e_grant", grant_id, 0);
        chk("e_err", arb_err, 0);
        m1_ar_valid = 1; m1_araddr = 64'h600; m1_arlen = 0;
        settle();
        chk("e_m1_ready", m1_ar_ready, 1);
        tick();
        m1_ar_valid = 0;
        chk("e_s_araddr_new", s_araddr, 64'h600);
        s_ar_ready = 1; tick(); s_ar_ready = 0;
        s_r_valid = 1; s_rlast = 1; s_rdata = 64'hBEEF;
        settle();
        chk("e_m1_rvalid", m1_r_valid, 1);
        chk("e_m1_rdata", m1_rdata, 64'hBEEF);
        tick();
        s_r_valid = 0; s_rlast = 0;
        chk("e_err_end", arb_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
